// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults and slot state encoding for stream_demux.
//   DEFAULT_WIDTH  data width of every channel
//   DEFAULT_CNT_W  width of the optional per-channel transfer counters
//   SLOT_EMPTY / SLOT_FULL  holding-register state constants
package stream_demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for one output channel of stream_demux.
// Optional macro: STREAM_DEMUX_CNT_EN adds an accepted-word counter (o_cnt).
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   i_load      accept routed to this slot this cycle (writes i_data)
//   i_data      word to store on i_load
//   i_ready     consumer ready
//   o_valid     slot is FULL
//   o_data      stored word
//   o_cnt       accepted-word count, wraps (STREAM_DEMUX_CNT_EN only)
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef STREAM_DEMUX_CNT_EN
   ,parameter int unsigned CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [CNT_W-1:0] o_cnt
`endif
);

    logic             r_state;
    logic [WIDTH-1:0] r_data;
    logic             w_take;

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;
    assign w_take  = o_valid && i_ready;

    // A load wins over a take: on a simultaneous handshake the new word replaces the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else if (i_load) begin
            r_state <= SLOT_FULL;
        end else if (w_take) begin
            r_state <= SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 result steering unit. Accepts one word per cycle and
// delivers it one cycle later on channel 0 or 1 according to sel. Each channel has its own
// one-entry holding register, so a stalled channel never blocks the other.
// Optional macro: STREAM_DEMUX_CNT_EN adds per-channel accepted-word counters cnt0/cnt1.
// Ports:
//   clk, rst                clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready       input handshake
//   in_data, sel            input word and destination (0 -> ch0, 1 -> ch1)
//   outN_valid/outN_ready   output handshake of channel N
//   outN_data               holding register of channel N
//   cnt0, cnt1              accepted-word counts (STREAM_DEMUX_CNT_EN only)
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    if (CNT_W == 0) begin : g_cnt_w_check
        $error("stream_demux: CNT_W must be nonzero");
    end

    logic w_accept;
    logic w_load0;
    logic w_load1;

    // Ready follows only the selected channel, never in_valid.
    assign in_ready = sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && !sel;
    assign w_load1  = w_accept && sel;

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
       ,.CNT_W (CNT_W)
`endif
    ) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data)
`ifdef STREAM_DEMUX_CNT_EN
       ,.o_cnt   (cnt0)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
       ,.CNT_W (CNT_W)
`endif
    ) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data)
`ifdef STREAM_DEMUX_CNT_EN
       ,.o_cnt   (cnt1)
`endif
    );

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 result steering unit for the MIPS datapath. It accepts one 32-bit word per cycle on a valid/ready input channel and delivers it, with one cycle of latency, to output channel 0 or 1 according to `sel`. Each output has a one-entry holding register, so a stalled destination never blocks traffic headed to the other one. It sits between the writeback result source and its two consumers: the register-file write path and the HI/LO/forwarding path.

## Interface
- `WIDTH`, 32, data width of every channel
- `CNT_W`, 16, width of per-channel transfer counters (used only with `STREAM_DEMUX_CNT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input word present
- `in_ready`  out  1  input word accepted this cycle when `in_valid && in_ready`
- `in_data`  in  WIDTH  input word
- `sel`  in  1  destination: 0 selects channel 0, 1 selects channel 1; sampled with `in_data`
- `out0_valid`, `out1_valid`  out  1  holding register of channel 0/1 is full
- `out0_ready`, `out1_ready`  in  1  consumer takes the word when valid && ready
- `out0_data`, `out1_data`  out  WIDTH  holding register contents
- `cnt0`, `cnt1`  out  CNT_W  accepted-word counts (only with `STREAM_DEMUX_CNT_EN`)

## Operation
- Each channel has a slot with two states:
  - EMPTY goes to FULL on an input accept routed to it.
  - FULL goes to EMPTY on an output handshake with no new accept.
  - FULL stays FULL on a simultaneous handshake and accept: the new word replaces the old one.
- `in_ready = !outN_valid || outN_ready` for N = `sel`. It is combinational from `sel`, the slot state and that channel's ready. It never depends on `in_valid`.
- An accept writes `in_data` only into the selected slot. The unselected slot is unaffected and can drain in the same cycle.
- `outN_data` holds its value while `outN_valid` is high and `outN_ready` is low. Words never drop or duplicate.
- Order is preserved per channel. There is no ordering guarantee between channels.
- Contents of an EMPTY slot are don't-care. Verification checks data only when valid is high.
- Reset: `rst` high immediately forces both slots EMPTY: `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`, counters = 0. A word in flight is discarded. `in_ready` is 1 during and after reset.

## Timing
- Latency is 1 cycle. A word accepted at edge k appears on `outN_data` with `outN_valid = 1` after edge k.
- Throughput is 1 word/cycle per channel when the consumer holds ready high. This holds for alternating `sel` and for back-to-back accepts to the same channel.
- Full, ready-low channel with `sel` pointing at it: `in_ready = 0`. Upstream holds `in_valid`, `in_data` and `sel` stable until accept.
- Upstream must not change `sel` while `in_valid` is high and not yet accepted.
- Reset deassertion is synchronous to `clk` by the system. The first accept is possible at the first edge after `rst` falls.

## Configuration
- `STREAM_DEMUX_CNT_EN` defined:
  - `cnt0` and `cnt1` increment by 1 on each accept routed to their channel.
  - They wrap modulo 2^CNT_W and reset to 0.
- `STREAM_DEMUX_CNT_EN` undefined: counters and ports `cnt0`/`cnt1` are absent, and no counter logic is generated.

## Structure
- Package `stream_demux_pkg` holds:
  - the `WIDTH`/`CNT_W` defaults
  - the slot state constants `SLOT_EMPTY` and `SLOT_FULL`
- Sub-module `demux_slot`: one holding register with its valid flag, load/take logic and optional counter. It is instantiated twice. The top level holds only the `sel` decode and the `in_ready` mux.

## Test plan
- Reset: assert `rst` mid-stream while both slots are FULL -> both valids 0, data 0, `in_ready` 1, counters 0, all without waiting for a clock edge.
- Single word: `in_data = 32'hDEADBEEF`, `sel = 1`, `out1_ready = 1` -> `out1_valid` high one cycle later with `DEADBEEF`; `out0_valid` stays 0.
- Back-pressure: `out0_ready = 0`, send `0x11` then `0x22` to ch0 -> `0x11` held on `out0_data`, `in_ready = 0` while `0x22` is presented. Raise `out0_ready` -> `0x22` accepted that cycle and appears the next cycle.
- Independence: ch0 full and stalled, send `0x33` with `sel = 1`, `out1_ready = 1` -> accepted immediately; `0x33` on `out1_data` one cycle later; ch0 word unchanged.
- Full-rate alternate: 8 words `1..8` with alternating `sel`, both readies high -> ch0 receives 1,3,5,7 and ch1 receives 2,4,6,8; `in_ready` never drops. With the macro defined, `cnt0 = cnt1 = 4`.
- Counter wrap (macro defined, `CNT_W = 4`): 17 accepts to ch1 -> `cnt1 = 1`.
